// File: rtl/seq_mult.sv
// seq_mult: sequential shift-and-add multiplier with valid/ready handshakes.
// Retires one multiplier bit per cycle; latency is fixed at WB cycles.
// Optional feature: define SEQ_MULT_SIGNED_EN for two's-complement operands
// (sign-magnitude conversion around the unsigned datapath).
module seq_mult #(
    parameter int unsigned WA = 4,
    parameter int unsigned WB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    multiplicand,
    input  logic [WB-1:0]    multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WA+WB-1:0] product,
    output logic             busy
);

    localparam int unsigned WP   = WA + WB;
    localparam int unsigned CntW = (WB > 1) ? $clog2(WB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [WP-1:0]   mcand_q, mcand_d;
    logic [WB-1:0]   mplier_q, mplier_d;
    logic [WP-1:0]   acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WP-1:0]   product_q, product_d;

    // Accumulator value after this cycle's conditional add.
    logic [WP-1:0]   acc_step;
    // Operand magnitudes captured at accept.
    logic [WA-1:0]   a_mag;
    logic [WB-1:0]   b_mag;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_d;
`endif

    // Operand conditioning: magnitudes for signed mode, pass-through otherwise.
    always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
        // Most-negative value negates to itself, which read unsigned is 2^(W-1).
        a_mag = multiplicand[WA-1] ? (~multiplicand + WA'(1)) : multiplicand;
        b_mag = multiplier[WB-1]   ? (~multiplier + WB'(1))   : multiplier;
`else
        a_mag = multiplicand;
        b_mag = multiplier;
`endif
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = WP'(a_mag);
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d   = multiplicand[WA-1] ^ multiplier[WB-1];
`endif
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
`ifdef SEQ_MULT_SIGNED_EN
                    product_d = sign_q ? (-acc_step) : acc_step;
`else
                    product_d = acc_step;
`endif
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign out_valid = (state_q == StDone);
    assign product   = product_q;

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential shift-and-add multiplier; successor to the combinational fixed 4x4 multiplier.
- Multiplies a WA-bit multiplicand by a WB-bit multiplier and produces a WA+WB-bit product.
- Retires one multiplier bit per cycle behind valid/ready handshakes on both input and output.
- Used where a full-array multiplier is too large, or where results must be pipelined into downstream handshaked logic.

Parameters:
- WA, 4, multiplicand width in bits (>=1)
- WB, 4, multiplier width in bits (>=1); equals compute latency in cycles

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- multiplicand  input  WA  operand A
- multiplier  input  WB  operand B
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  WA+WB  A*B
- busy  output  1  high in BUSY state

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; product=0.
  - Internal accumulator, shift registers and bit counter cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid&&in_ready: latch multiplicand zero-extended to WA+WB, latch multiplier; acc=0; cnt=0; go BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle: if multiplier LSB=1 then acc+=shifted multiplicand (mod 2^(WA+WB)); multiplicand<<=1; multiplier>>=1; cnt++.
  - After WB cycles (cnt==WB-1 on that edge): product<=final acc; go DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - product held stable while out_valid && !out_ready.
  - On edge with out_ready: out_valid=0; go IDLE.
- Latency:
  - Input handshake at edge E0.
  - out_valid high after edge E0+WB (WB BUSY cycles).
  - Minimum initiation interval WB+2 cycles.
- Arithmetic: unsigned; the exact product always fits in WA+WB bits, so there is no overflow.
- No early termination: latency is fixed at WB regardless of operand values (0, 1, all-ones all take WB cycles).
- in_valid while not in_ready: ignored; operands are not captured and the upstream must hold them.
- out_ready while !out_valid: ignored.
- No simultaneous accept/release: in_ready is 0 in DONE, so a new input is accepted the cycle after the output handshake.
- Reset mid-operation (BUSY or DONE): immediate return to IDLE with reset values; the pending result is discarded.
- product register retains the last value in IDLE; it is only meaningful while out_valid=1.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - At accept, latch the magnitudes |A| and |B| (WA and WB bits, treated unsigned; the most-negative value maps correctly as 2^(W-1)) and sign = A[WA-1]^B[WB-1].
  - Perform the unsigned shift-add as above.
  - On the BUSY->DONE edge, product <= sign ? -acc : acc (two's complement, WA+WB bits).
  - Latency is unchanged.
- Undefined: purely unsigned behaviour as specified; no sign logic synthesised.

Test Plan:
- WA=WB=4, reset then A=13, B=11, out_ready=1 -> out_valid rises exactly 4 cycles after accept; product=143 (0x8F); back to IDLE next cycle.
- Corners, one operation each: A=15, B=15 -> 225 (0xE1); A=0, B=9 -> 0; A=1, B=1 -> 1. Each must take exactly 4 BUSY cycles.
- Backpressure: A=7, B=6 with out_ready=0 for 5 cycles -> product=42 held stable and out_valid held; in_ready=0 throughout; in_valid pulses with A=3, B=3 during the stall are not captured. After release, the next accepted op completes.
- Reset mid-op: accept A=9, B=9; assert rst_n=0 at BUSY cycle 2 -> out_valid=0, in_ready=1, busy=0 immediately. After deassert, A=2, B=5 -> 10 with no residue from the aborted op.
- Parametric: WA=8, WB=3, A=255, B=7 -> product=1785 (11 bits, 0x6F9) after 3 BUSY cycles.
- SEQ_MULT_SIGNED_EN defined, WA=WB=4:
  - A=-8, B=7 -> 0xC8 (-56)
  - A=-8, B=-8 -> 0x40 (64)
  - A=5, B=-3 -> 0xF1 (-15)
